clint_timer_slave: RTL
======================

// Module: clint_timer_slave
// PURPOSE
//   Bus responder on the CPU data bus implementing the RISC-V CLINT for xv6: 64-bit mtime,
//   64-bit mtimecmp, msip. Answers CPU load/store requests (i_bus_DV strobe) with a
//   one-cycle o_bus_DV response and drives machine timer/software interrupt levels.
//   Sits in memory_top beside the other MMIO slaves; memory_top muxes its o_bus_data/o_bus_DV.
// PARAMETERS
//   BASE_ADDR   32'h0200_0000  base of the 64 KiB CLINT window (address[31:16] match)
//   TICK_DIV    10             i_clk cycles per mtime increment (>=1)
// PORTS
//   i_clk            in   1   system clock
//   i_rst_n          in   1   asynchronous active-low reset
//   i_bus_address    in   32  request byte address, valid when i_bus_DV=1
//   i_bus_data       in   32  write data (right-aligned for byte/half)
//   i_bus_DV         in   1   request strobe, one cycle per request
//   i_bhw            in   3   access size: 3'b001 byte, 3'b010 half, 3'b100 word
//   i_write_notread  in   1   1=store, 0=load
//   i_sel            in   1   chip select from memory_top decoder (ANDed with window match)
//   o_bus_data       out  32  read data (right-aligned), 0 when o_bus_DV=0
//   o_bus_DV         out  1   response strobe, one cycle
//   o_timer_irq      out  1   MTIP level: mtime >= mtimecmp (unsigned 64-bit)
//   o_soft_irq       out  1   MSIP level: msip[0]
// BEHAVIOUR
// - Reset (async, i_rst_n=0): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0,
//   o_bus_DV=0, o_bus_data=0, o_timer_irq=0, o_soft_irq=0. Reset mid-request drops it; no response.
// - Register map (offset = address[15:0]): 0x0000 msip (bit0 RW, others RAZ/WI);
//   0x4000/0x4004 mtimecmp lo/hi; 0xBFF8/0xBFFC mtime lo/hi. Other offsets: RAZ/WI.
// - Accepted request = i_bus_DV & i_sel & (address[31:16]==BASE_ADDR[31:16]); others ignored, no DV.
// - Response: registered; o_bus_DV=1 exactly in the cycle after acceptance, for loads and
//   stores alike; o_bus_data valid that cycle, forced 0 otherwise. Back-to-back requests
//   every cycle are legal; each gets its own response one cycle later. No stall path.
// - Loads: 32-bit word at address[15:2]; byte/half select lane address[1:0] and right-align,
//   zero-extended (CPU sign-extends). Read value is the register before this cycle's update.
// - Stores: byte lane address[1:0] for byte, half at address[1] for half, full word otherwise;
//   only addressed bytes change. Misaligned half (address[0]=1) or word (address[1:0]!=0): WI, still DV.
// - Prescaler: counts 0..TICK_DIV-1, mtime += 1 (64-bit, carry lo->hi) when it wraps.
//   mtime wraps 2^64-1 -> 0. Store to mtime in a tick cycle: store wins, increment dropped,
//   prescaler keeps running. Store to mtime lo does not touch hi and vice versa.
// - o_timer_irq registered from mtime >= mtimecmp using post-update values: asserts 1 cycle
//   after the cycle mtime reaches mtimecmp; deasserts 1 cycle after a mtimecmp store makes
//   it greater. Level only; cleared solely by raising mtimecmp (or lowering mtime).
// - o_soft_irq = msip[0] register, changes 1 cycle after the store.
// - No internal ack path; interrupt acknowledgement lives in PLIC / CPU CSR logic.
// TESTING
// - Reset then word load 0x0200_4004 -> o_bus_DV 1 cycle later, data 32'hFFFF_FFFF; irqs 0.
// - TICK_DIV=10, idle 100 cycles, load 0x0200_BFF8 -> data 10 (+/-1 per prescaler phase), hi 0.
// - Store mtime lo=32'hFFFF_FFFF, hi=0; wait TICK_DIV -> hi reads 1, lo reads 0 (carry).
// - mtimecmp=0x20 (hi=0 first): o_timer_irq rises exactly 1 cycle after mtime==0x20;
//   store mtimecmp lo=0x1000 -> o_timer_irq falls 1 cycle later.
// - Byte store 0x01 to 0x0200_0000 -> o_soft_irq=1; byte store 0x0 -> 0; load returns 1/0.
// - Request with i_sel=0 or 0x0300_0000 -> no o_bus_DV; two back-to-back loads -> two DV pulses.

Source files
------------

// File: rtl/clint_timer_slave.sv
// clint_timer_slave: RISC-V CLINT bus responder with mtime/mtimecmp/msip and MTIP/MSIP levels.
// Single-cycle registered response; stores are byte-lane merged into the addressed word.
module clint_timer_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 10
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_bus_address,
   input  logic [31:0] i_bus_data,
   input  logic        i_bus_DV,
   input  logic [2:0]  i_bhw,
   input  logic        i_write_notread,
   input  logic        i_sel,
   output logic [31:0] o_bus_data,
   output logic        o_bus_DV,
   output logic        o_timer_irq,
   output logic        o_soft_irq
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic [63:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
   logic          msip_q, msip_d;
   logic          dv_q, tirq_q;
   logic [31:0]   data_q;

   logic        accept, wr, tick, is_b, is_h, mt_wr, cmp_wr;
   logic        s_msip, s_cmp_lo, s_cmp_hi, s_mt_lo, s_mt_hi;
   logic [13:0] widx;
   logic [3:0]  be;
   logic [31:0] wdat, wmask, rd_word, sh_b, sh_h, rd_lane;

   always_comb begin
      accept   = i_bus_DV & i_sel & (i_bus_address[31:16] == BASE_ADDR[31:16]);
      wr       = accept & i_write_notread;
      widx     = i_bus_address[15:2];
      s_msip   = widx == 14'h0000;
      s_cmp_lo = widx == 14'h1000;
      s_cmp_hi = widx == 14'h1001;
      s_mt_lo  = widx == 14'h2FFE;
      s_mt_hi  = widx == 14'h2FFF;
      is_b     = i_bhw == 3'b001;
      is_h     = i_bhw == 3'b010;
      tick     = pre_q == PW'(TICK_DIV - 1);
      pre_d    = tick ? '0 : pre_q + PW'(1);
      rd_word  = s_msip   ? {31'b0, msip_q}     :
                 s_cmp_lo ? mtimecmp_q[31:0]    :
                 s_cmp_hi ? mtimecmp_q[63:32]   :
                 s_mt_lo  ? mtime_q[31:0]       :
                 s_mt_hi  ? mtime_q[63:32]      : '0;
      sh_b     = rd_word >> {i_bus_address[1:0], 3'b000};
      sh_h     = rd_word >> {i_bus_address[1], 4'b0000};
      rd_lane  = is_b ? {24'b0, sh_b[7:0]} : is_h ? {16'b0, sh_h[15:0]} : rd_word;
      // Misaligned half/word stores get an empty byte mask so they are ignored but still answered.
      be       = is_b ? (4'b0001 << i_bus_address[1:0]) :
                 is_h ? (i_bus_address[0] ? 4'b0000 : i_bus_address[1] ? 4'b1100 : 4'b0011) :
                 (i_bus_address[1:0] == 2'b00 ? 4'b1111 : 4'b0000);
      wdat     = is_b ? {4{i_bus_data[7:0]}} : is_h ? {2{i_bus_data[15:0]}} : i_bus_data;
      wmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      mt_wr    = wr & (s_mt_lo | s_mt_hi) & (|be);
      cmp_wr   = wr & (s_cmp_lo | s_cmp_hi);
      // A store to either mtime half wins over the tick; the other half keeps its old value.
      mtime_d  = mt_wr ? {s_mt_hi ? ((mtime_q[63:32] & ~wmask) | (wdat & wmask)) : mtime_q[63:32],
                          s_mt_lo ? ((mtime_q[31:0] & ~wmask) | (wdat & wmask)) : mtime_q[31:0]}
                       : mtime_q + 64'(tick);
      mtimecmp_d = cmp_wr ? {s_cmp_hi ? ((mtimecmp_q[63:32] & ~wmask) | (wdat & wmask)) : mtimecmp_q[63:32],
                             s_cmp_lo ? ((mtimecmp_q[31:0] & ~wmask) | (wdat & wmask)) : mtimecmp_q[31:0]}
                          : mtimecmp_q;
      msip_d   = (wr & s_msip & be[0]) ? wdat[0] : msip_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pre_q      <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
         dv_q       <= 1'b0;
         data_q     <= '0;
         tirq_q     <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         dv_q       <= accept;
         data_q     <= (accept & ~i_write_notread) ? rd_lane : '0;
         tirq_q     <= mtime_d >= mtimecmp_d;
      end
   end

   assign o_bus_DV    = dv_q;
   assign o_bus_data  = data_q;
   assign o_timer_irq = tirq_q;
   assign o_soft_irq  = msip_q;
endmodule
